// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the two-port SDRAM request arbiter:
//   - arb_state_t : transaction sequencer states
//   - DEF_*       : default address/data widths and read-completion timeout
//   - PORT_0/1    : requester indices (0 = instruction fetch, 1 = data)
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W  = 23;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;

endpackage

// File: rtl/sdram_arb_rr2.sv
// ---------------------------------------------------------------------------
// sdram_arb_rr2
// Combinational two-way round-robin picker.
//   req[1:0]    in   request vector (bit N = port N)
//   last_grant  in   index of the port served most recently
//   grant[1:0]  out  one-hot winner, 0 when nothing is requested
// With a single requester that port wins outright; on a tie the port that
// was not served last wins.
// ---------------------------------------------------------------------------
module sdram_arb_rr2
    import sdram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == PORT_1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_req_arbiter
// Shares the single sdram_controller user port between two requesters.
// One request is latched at a time, issued with in_valid until the
// controller is not busy, and completed with a one-cycle ack. Reads wait
// for out_valid, bounded by TIMEOUT cycles; a timed-out read acks with err=1
// and rdata=0.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   mN_req/we/addr/wdata          requester N inputs (held until ack)
//   mN_ack/err/rdata              requester N completion (registered)
//   ctrl_addr/rw/wdata/in_valid   to controller user port (registered)
//   ctrl_busy/out_valid/rdata     from controller
//   grant                         one-hot owner of current transaction
// ---------------------------------------------------------------------------
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] ctrl_addr,
    output logic              ctrl_rw,
    output logic [DATA_W-1:0] ctrl_wdata,
    output logic              ctrl_in_valid,
    input  logic              ctrl_busy,
    input  logic              ctrl_out_valid,
    input  logic [DATA_W-1:0] ctrl_rdata,

    output logic [1:0]        grant
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_reg;
    logic              last_grant_reg;
    logic [1:0]        grant_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [1:0]        ack_reg;
    logic [1:0]        err_reg;
    logic [DATA_W-1:0] rdata0_reg;
    logic [DATA_W-1:0] rdata1_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              rw_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              in_valid_reg;

    logic [1:0]        pick;

    sdram_arb_rr2 u_rr2 (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_reg),
        .grant      (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= PORT_1;   // port 0 wins the first tie
            grant_reg      <= 2'b00;
            cnt_reg        <= '0;
            ack_reg        <= 2'b00;
            err_reg        <= 2'b00;
            rdata0_reg     <= '0;
            rdata1_reg     <= '0;
            addr_reg       <= '0;
            rw_reg         <= 1'b0;
            wdata_reg      <= '0;
            in_valid_reg   <= 1'b0;
        end else begin
            // ack/err are single-cycle pulses; only the transition into
            // DONE raises them.
            ack_reg <= 2'b00;
            err_reg <= 2'b00;

            case (state_reg)
                IDLE: begin
                    if (|pick) begin
                        // Only the winner's fields are sampled, once.
                        grant_reg    <= pick;
                        rw_reg       <= pick[1] ? m1_we    : m0_we;
                        addr_reg     <= pick[1] ? m1_addr  : m0_addr;
                        wdata_reg    <= pick[1] ? m1_wdata : m0_wdata;
                        in_valid_reg <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (!ctrl_busy) begin
                        in_valid_reg <= 1'b0;
                        cnt_reg      <= '0;
                        if (rw_reg) begin
                            ack_reg   <= grant_reg;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= WAIT_RD;
                        end
                    end
                end

                WAIT_RD: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    // Data arriving on the last allowed cycle still wins
                    // over the timeout.
                    if (ctrl_out_valid) begin
                        if (grant_reg[1]) begin
                            rdata1_reg <= ctrl_rdata;
                        end else begin
                            rdata0_reg <= ctrl_rdata;
                        end
                        ack_reg   <= grant_reg;
                        state_reg <= DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        if (grant_reg[1]) begin
                            rdata1_reg <= '0;
                        end else begin
                            rdata0_reg <= '0;
                        end
                        ack_reg   <= grant_reg;
                        err_reg   <= grant_reg;
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    last_grant_reg <= grant_reg[1] ? PORT_1 : PORT_0;
                    grant_reg      <= 2'b00;
                    state_reg      <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign m0_ack        = ack_reg[0];
    assign m1_ack        = ack_reg[1];
    assign m0_err        = err_reg[0];
    assign m1_err        = err_reg[1];
    assign m0_rdata      = rdata0_reg;
    assign m1_rdata      = rdata1_reg;
    assign ctrl_addr     = addr_reg;
    assign ctrl_rw       = rw_reg;
    assign ctrl_wdata    = wdata_reg;
    assign ctrl_in_valid = in_valid_reg;
    assign grant         = grant_reg;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_req_arbiter
// Directed bench for sdram_req_arbiter (TIMEOUT = 4). A transaction-level
// model tracks the owner, acceptance cycle and completion cycle of each
// request and is compared against the DUT every negative clock edge;
// directed sequences add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_sdram_req_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack, m0_err;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack, m1_err;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] ctrl_addr;
    logic          ctrl_rw, ctrl_in_valid;
    logic [DW-1:0] ctrl_wdata;
    logic          ctrl_busy = 1'b0, ctrl_out_valid = 1'b0;
    logic [DW-1:0] ctrl_rdata = '0;
    logic [1:0]    grant;

    sdram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_wdata(ctrl_wdata),
        .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
        .ctrl_out_valid(ctrl_out_valid), .ctrl_rdata(ctrl_rdata),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;
    int ack_cnt [2] = '{0, 0};
    int win_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model and per-cycle compare
    // ------------------------------------------------------------------
    initial begin
        int            cyc;
        bit            md_active, md_accepted, md_last, md_port, md_we, md_err;
        logic [AW-1:0] md_addr;
        logic [DW-1:0] md_wdata, md_rdata;
        int            md_ack_at, md_wait_start;
        logic [1:0]    eg;
        bit            eiv, eack;
        cyc = 0; md_active = 0; md_accepted = 0; md_last = 1; md_port = 0;
        md_we = 0; md_err = 0; md_addr = '0; md_wdata = '0; md_rdata = '0;
        md_ack_at = -1; md_wait_start = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (started && !rst_n) begin
                md_active = 0; md_accepted = 0; md_last = 1; md_ack_at = -1;
                check("rst_grant", grant, 2'b00);
                check("rst_in_valid", ctrl_in_valid, 1'b0);
                check("rst_acks", {m1_ack, m0_ack}, 2'b00);
            end else if (started) begin
                eg   = md_active ? (md_port ? 2'b10 : 2'b01) : 2'b00;
                eiv  = md_active && !md_accepted;
                eack = md_active && (md_ack_at == cyc);
                check("grant", grant, eg);
                check("in_valid", ctrl_in_valid, eiv);
                check("m0_ack", m0_ack, eack && !md_port);
                check("m1_ack", m1_ack, eack && md_port);
                check("m0_err", m0_err, eack && !md_port && md_err);
                check("m1_err", m1_err, eack && md_port && md_err);
                if (eiv) begin
                    check("ctrl_addr", ctrl_addr, md_addr);
                    check("ctrl_rw", ctrl_rw, md_we);
                    check("ctrl_wdata", ctrl_wdata, md_wdata);
                end
                if (eack && !md_we) begin
                    check("rdata", md_port ? m1_rdata : m0_rdata, md_rdata);
                end
                if (m0_ack) begin ack_cnt[0]++; win_q.push_back(0); end
                if (m1_ack) begin ack_cnt[1]++; win_q.push_back(1); end

                // Advance the model to the next cycle.
                if (!md_active) begin
                    if (m0_req || m1_req) begin
                        md_port     = (m0_req && m1_req) ? !md_last : m1_req;
                        md_we       = md_port ? m1_we : m0_we;
                        md_addr     = md_port ? m1_addr : m0_addr;
                        md_wdata    = md_port ? m1_wdata : m0_wdata;
                        md_active   = 1; md_accepted = 0; md_ack_at = -1; md_err = 0;
                    end
                end else if (md_ack_at == cyc) begin
                    md_active = 0;
                    md_last   = md_port;
                end else if (!md_accepted) begin
                    if (!ctrl_busy) begin
                        md_accepted = 1;
                        if (md_we) md_ack_at = cyc + 1;
                        else md_wait_start = cyc + 1;
                    end
                end else if (md_ack_at < 0) begin
                    if (ctrl_out_valid) begin
                        md_ack_at = cyc + 1; md_rdata = ctrl_rdata;
                    end else if (cyc - md_wait_start + 1 >= TO) begin
                        md_ack_at = cyc + 1; md_err = 1; md_rdata = '0;
                    end
                end
            end
        end
    end

    // Wait for an ack on one port, counting clock edges from now.
    task automatic wait_ack(input int port, input int budget, output int n);
        bit got;
        got = 0; n = -1;
        for (int i = 1; i <= budget && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((port == 0) ? m0_ack : m1_ack) begin
                got = 1; n = i;
            end
        end
        check("wait_ack_bound", got, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int n, tot, base0, base1, qbase;
        bit done;

        // Reset
        #3 rst_n = 1'b0;
        #1 started = 1'b1;
        check("reset_grant", grant, 2'b00);
        check("reset_in_valid", ctrl_in_valid, 1'b0);
        check("reset_acks", {m1_ack, m0_ack, m1_err, m0_err}, 4'b0000);
        check("reset_m0_rdata", m0_rdata, 32'h0);
        check("reset_ctrl_addr", ctrl_addr, 23'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1) m0 write, no busy
        @(posedge clk); #1;
        m0_req = 1; m0_we = 1; m0_addr = 23'h000010; m0_wdata = 32'hDEADBEEF;
        @(posedge clk); @(negedge clk);
        check("wr_in_valid_c1", ctrl_in_valid, 1'b1);
        check("wr_addr_c1", ctrl_addr, 23'h000010);
        check("wr_wdata_c1", ctrl_wdata, 32'hDEADBEEF);
        check("wr_rw_c1", ctrl_rw, 1'b1);
        wait_ack(0, 10, n);
        check("wr_ack_latency", n + 1, 2);
        check("wr_err", m0_err, 1'b0);
        @(posedge clk); #1 m0_req = 0;

        // 2) m1 read, out_valid three cycles into WAIT_RD
        @(posedge clk); #1;
        m1_req = 1; m1_we = 0; m1_addr = 23'h7FFFFF;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            ctrl_out_valid = (c == 4);
            ctrl_rdata     = (c == 4) ? 32'h12345678 : 32'hAAAA5555;
            @(negedge clk);
            check("rd_grant", grant, 2'b10);
            check("rd_m1_ack", m1_ack, c == 5);
        end
        check("rd_m1_rdata", m1_rdata, 32'h12345678);
        @(posedge clk); #1 m1_req = 0; ctrl_out_valid = 0;

        // 3) Contention: both ports write continuously, 8 transactions
        @(posedge clk); #1;
        m0_req = 1; m0_we = 1; m0_addr = 23'h000100; m0_wdata = 32'h00000A0A;
        m1_req = 1; m1_we = 1; m1_addr = 23'h000200; m1_wdata = 32'h0000B1B1;
        base0 = ack_cnt[0]; base1 = ack_cnt[1]; qbase = win_q.size();
        done = 0; n = -1;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(posedge clk); @(negedge clk); #1;
            tot = (ack_cnt[0] - base0) + (ack_cnt[1] - base1);
            if (tot == 8) begin done = 1; n = i; end
        end
        check("rr_done", done, 1'b1);
        check("rr_cycles", n, 23);
        @(posedge clk); #1 m0_req = 0; m1_req = 0;
        check("rr_acks_m0", ack_cnt[0] - base0, 4);
        check("rr_acks_m1", ack_cnt[1] - base1, 4);
        if (win_q.size() >= qbase + 8) begin
            for (int k = 0; k < 8; k++) begin
                check("rr_order", win_q[qbase + k], k % 2);
            end
        end else begin
            check("rr_order_len", win_q.size() - qbase, 8);
        end

        // 4) Busy stall for 6 ISSUE cycles; winner address changes mid-flight
        @(posedge clk); #1;
        m1_req = 1; m1_we = 1; m1_addr = 23'h000ABC; m1_wdata = 32'hCAFEF00D;
        ctrl_busy = 1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            ctrl_busy = (c <= 6);
            if (c == 3) m1_addr = 23'h000555;
            @(negedge clk);
            if (c <= 7) begin
                check("busy_in_valid", ctrl_in_valid, 1'b1);
                check("busy_addr", ctrl_addr, 23'h000ABC);
                check("busy_wdata", ctrl_wdata, 32'hCAFEF00D);
            end
            check("busy_m1_ack", m1_ack, c == 8);
        end
        @(posedge clk); #1 m1_req = 0; ctrl_busy = 0;

        // 5) m0 read: out_valid on the last allowed WAIT_RD cycle
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 23'h000030;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            ctrl_out_valid = (c == 5);
            ctrl_rdata     = (c == 5) ? 32'h0BADF00D : 32'h11111111;
            @(negedge clk);
            check("edge_m0_ack", m0_ack, c == 6);
        end
        check("edge_m0_err", m0_err, 1'b0);
        check("edge_m0_rdata", m0_rdata, 32'h0BADF00D);
        @(posedge clk); #1 m0_req = 0; ctrl_out_valid = 0;

        // 6) m0 read timeout, then stray out_valid in IDLE
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 23'h000020;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); @(negedge clk);
            check("to_in_valid", ctrl_in_valid, c == 1);
            check("to_m0_ack", m0_ack, c == 6);
        end
        check("to_m0_err", m0_err, 1'b1);
        check("to_m0_rdata", m0_rdata, 32'h0);
        for (int c = 7; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c == 7) m0_req = 0;
            ctrl_out_valid = (c <= 8);
            ctrl_rdata     = 32'hFFFFFFFF;
            @(negedge clk);
            check("stray_acks", {m1_ack, m0_ack}, 2'b00);
        end
        @(posedge clk); #1 ctrl_out_valid = 0;

        // 7) Reset while m1 waits for read data; tie afterwards goes to m0
        @(posedge clk); #1;
        m1_req = 1; m1_we = 0; m1_addr = 23'h000040;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); @(negedge clk);
        end
        check("pre_rst_grant", grant, 2'b10);
        @(posedge clk); #1;
        rst_n = 0;
        m0_req = 1; m0_we = 1; m0_addr = 23'h000050; m0_wdata = 32'h5A5A5A5A;
        m1_we = 1; m1_wdata = 32'h6B6B6B6B;
        #1;
        check("async_rst_grant", grant, 2'b00);
        check("async_rst_in_valid", ctrl_in_valid, 1'b0);
        check("async_rst_acks", {m1_ack, m0_ack}, 2'b00);
        @(posedge clk); #1 rst_n = 1;
        wait_ack(0, 10, n);
        check("post_rst_m0_first", n, 2);
        @(posedge clk); #1 m0_req = 0;
        wait_ack(1, 10, n);
        check("post_rst_m1_next", n, 2);
        @(posedge clk); #1 m1_req = 0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
